// File: rtl/blob_bbox_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : blob_bbox_accumulator_if
// Purpose  : Bundles the frame control, run/merge input and result output
//            signals of the blob bounding-box accumulator.
// Ports    : frame_start, frame_end       frame control pulses
//            run_valid/run_ready/run_*     labelled run segment handshake
//            merge_valid/merge_a/merge_b   label equivalence (fold b into a)
//            blob_*                        finished-frame result registers
//            err_sticky                    bit0 label range, bit1 end<start
// Modports : master (frame source / result consumer), slave (accumulator)
// Revision : 1.0 - initial release
// ============================================================================
interface blob_bbox_accumulator_if #(
  parameter int LABEL_W = 9,
  parameter int COORD_W = 11,
  parameter int AREA_W  = 20
);
  logic               frame_start;
  logic               frame_end;
  logic               run_valid;
  logic               run_ready;
  logic [COORD_W-1:0] run_row;
  logic [COORD_W-1:0] run_start;
  logic [COORD_W-1:0] run_end;
  logic [LABEL_W-1:0] run_label;
  logic               merge_valid;
  logic [LABEL_W-1:0] merge_a;
  logic [LABEL_W-1:0] merge_b;
  logic               blob_valid;
  logic               blob_found;
  logic [LABEL_W-1:0] blob_label;
  logic [COORD_W-1:0] blob_xmin;
  logic [COORD_W-1:0] blob_xmax;
  logic [COORD_W-1:0] blob_ymin;
  logic [COORD_W-1:0] blob_ymax;
  logic [AREA_W-1:0]  blob_area;
  logic [LABEL_W-1:0] blob_count;
  logic [1:0]         err_sticky;

  modport master (
    output frame_start, frame_end,
    output run_valid, run_row, run_start, run_end, run_label,
    output merge_valid, merge_a, merge_b,
    input  run_ready,
    input  blob_valid, blob_found, blob_label,
    input  blob_xmin, blob_xmax, blob_ymin, blob_ymax,
    input  blob_area, blob_count, err_sticky
  );

  modport slave (
    input  frame_start, frame_end,
    input  run_valid, run_row, run_start, run_end, run_label,
    input  merge_valid, merge_a, merge_b,
    output run_ready,
    output blob_valid, blob_found, blob_label,
    output blob_xmin, blob_xmax, blob_ymin, blob_ymax,
    output blob_area, blob_count, err_sticky
  );
endinterface
`default_nettype wire

// File: rtl/blob_bbox_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : blob_bbox_accumulator
// Purpose  : Accumulates per-label bounding box and pixel area from labelled
//            run-length segments, then scans the table at frame end and holds
//            the largest blob's box/area until the next frame starts.
// Ports    : VGA_IN_DATA_CLK  pixel clock (only clock)
//            rst_n            asynchronous active-low reset
//            bus              blob_bbox_accumulator_if.slave
// Options  : BLOB_MERGE_EN    when defined, the merge port folds label
//                             merge_b into merge_a; otherwise merge inputs
//                             are ignored and no merge logic is built.
// Revision : 1.0 - initial release
// ============================================================================
module blob_bbox_accumulator #(
  parameter int NUM_LABELS = 16,
  parameter int LABEL_W    = 9,
  parameter int COORD_W    = 11,
  parameter int AREA_W     = 20
) (
  input wire                      VGA_IN_DATA_CLK,
  input wire                      rst_n,
  blob_bbox_accumulator_if.slave  bus
);

  localparam int IDX_W  = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;
  localparam int SCAN_W = $clog2(NUM_LABELS + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_LABELS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
    logic [AREA_W-1:0]  area;
  } entry_t;

  function automatic logic [AREA_W-1:0] sat_add(input logic [AREA_W-1:0] a,
                                                 input logic [AREA_W-1:0] b);
    logic [AREA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AREA_W] ? {AREA_W{1'b1}} : s[AREA_W-1:0];
  endfunction

  state_t             state_q;
  entry_t             tbl_q [NUM_LABELS];
  entry_t             tbl_d [NUM_LABELS];
  logic [1:0]         err_q;
  logic [1:0]         err_d;

  // Scan bookkeeping
  logic [SCAN_W-1:0]  scan_idx_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [AREA_W-1:0]  best_area_q;
  logic               best_found_q;
  logic [LABEL_W-1:0] count_q;

  // Result registers
  logic               blob_valid_q;
  logic               found_q;
  logic [LABEL_W-1:0] label_q;
  logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [AREA_W-1:0]  area_q;
  logic [LABEL_W-1:0] res_count_q;

  logic               w_in_accum;
  logic               w_run_ready;
  logic               w_run_fire;
  logic               w_run_lbl_ok;
  logic               w_run_ord_ok;
  logic [COORD_W:0]   w_run_len;
  logic [IDX_W-1:0]   w_run_idx;
  entry_t             w_scan_e;

  assign w_in_accum   = (state_q == ST_ACCUM);
  assign w_run_lbl_ok = (32'(bus.run_label) < NUM_LABELS);
  assign w_run_ord_ok = (bus.run_end >= bus.run_start);
  assign w_run_len    = {1'b0, bus.run_end} - {1'b0, bus.run_start} + (COORD_W+1)'(1);
  assign w_run_idx    = bus.run_label[IDX_W-1:0];
  assign w_scan_e     = tbl_q[scan_idx_q[IDX_W-1:0]];

`ifdef BLOB_MERGE_EN
  logic             w_merge_fire;
  logic             w_merge_in_range;
  logic [IDX_W-1:0] w_ma;
  logic [IDX_W-1:0] w_mb;

  // A pending merge takes the table port, so the run waits a cycle.
  assign w_run_ready      = w_in_accum && !bus.merge_valid;
  assign w_merge_fire     = w_in_accum && bus.merge_valid;
  assign w_merge_in_range = (32'(bus.merge_a) < NUM_LABELS) &&
                            (32'(bus.merge_b) < NUM_LABELS);
  assign w_ma             = bus.merge_a[IDX_W-1:0];
  assign w_mb             = bus.merge_b[IDX_W-1:0];
`else
  logic w_unused_merge;
  assign w_unused_merge = ^{bus.merge_valid, bus.merge_a, bus.merge_b};
  assign w_run_ready    = w_in_accum;
`endif

  assign w_run_fire = bus.run_valid && w_run_ready;

  // Next-state of the label table and sticky error flags.
  always_comb begin
    for (int i = 0; i < NUM_LABELS; i++) tbl_d[i] = tbl_q[i];
    err_d = err_q;
    if (bus.frame_start) begin
      for (int i = 0; i < NUM_LABELS; i++) tbl_d[i].valid = 1'b0;
      err_d = 2'b00;
    end else begin
`ifdef BLOB_MERGE_EN
      if (w_merge_fire) begin
        if (!w_merge_in_range) begin
          err_d[0] = 1'b1;
        end else if ((w_ma != w_mb) && tbl_q[w_mb].valid) begin
          if (tbl_q[w_ma].valid) begin
            tbl_d[w_ma].xmin = (tbl_q[w_mb].xmin < tbl_q[w_ma].xmin) ? tbl_q[w_mb].xmin : tbl_q[w_ma].xmin;
            tbl_d[w_ma].xmax = (tbl_q[w_mb].xmax > tbl_q[w_ma].xmax) ? tbl_q[w_mb].xmax : tbl_q[w_ma].xmax;
            tbl_d[w_ma].ymin = (tbl_q[w_mb].ymin < tbl_q[w_ma].ymin) ? tbl_q[w_mb].ymin : tbl_q[w_ma].ymin;
            tbl_d[w_ma].ymax = (tbl_q[w_mb].ymax > tbl_q[w_ma].ymax) ? tbl_q[w_mb].ymax : tbl_q[w_ma].ymax;
            tbl_d[w_ma].area = sat_add(tbl_q[w_ma].area, tbl_q[w_mb].area);
          end else begin
            // Surviving label had no pixels yet: it simply inherits b's box.
            tbl_d[w_ma] = tbl_q[w_mb];
          end
          tbl_d[w_mb].valid = 1'b0;
        end
      end
`endif
      if (w_run_fire) begin
        if (!w_run_lbl_ok) err_d[0] = 1'b1;
        if (!w_run_ord_ok) err_d[1] = 1'b1;
        if (w_run_lbl_ok && w_run_ord_ok) begin
          if (!tbl_q[w_run_idx].valid) begin
            tbl_d[w_run_idx].valid = 1'b1;
            tbl_d[w_run_idx].xmin  = bus.run_start;
            tbl_d[w_run_idx].xmax  = bus.run_end;
            tbl_d[w_run_idx].ymin  = bus.run_row;
            tbl_d[w_run_idx].ymax  = bus.run_row;
            tbl_d[w_run_idx].area  = AREA_W'(w_run_len);
          end else begin
            tbl_d[w_run_idx].xmin = (bus.run_start < tbl_q[w_run_idx].xmin) ? bus.run_start : tbl_q[w_run_idx].xmin;
            tbl_d[w_run_idx].xmax = (bus.run_end   > tbl_q[w_run_idx].xmax) ? bus.run_end   : tbl_q[w_run_idx].xmax;
            tbl_d[w_run_idx].ymin = (bus.run_row   < tbl_q[w_run_idx].ymin) ? bus.run_row   : tbl_q[w_run_idx].ymin;
            tbl_d[w_run_idx].ymax = (bus.run_row   > tbl_q[w_run_idx].ymax) ? bus.run_row   : tbl_q[w_run_idx].ymax;
            tbl_d[w_run_idx].area = sat_add(tbl_q[w_run_idx].area, AREA_W'(w_run_len));
          end
        end
      end
    end
  end

  always_ff @(posedge VGA_IN_DATA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NUM_LABELS; i++) tbl_q[i] <= '0;
      err_q        <= 2'b00;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_area_q  <= '0;
      best_found_q <= 1'b0;
      count_q      <= '0;
      blob_valid_q <= 1'b0;
      found_q      <= 1'b0;
      label_q      <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      area_q       <= '0;
      res_count_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_LABELS; i++) tbl_q[i] <= tbl_d[i];
      err_q <= err_d;
      if (bus.frame_start) begin
        state_q      <= ST_ACCUM;
        blob_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ACCUM: begin
            if (bus.frame_end) begin
              state_q      <= ST_SCAN;
              scan_idx_q   <= '0;
              best_idx_q   <= '0;
              best_area_q  <= '0;
              best_found_q <= 1'b0;
              count_q      <= '0;
            end
          end
          ST_SCAN: begin
            if (scan_idx_q == SCAN_LAST) begin
              // All entries visited; publish the winner.
              state_q      <= ST_DONE;
              blob_valid_q <= 1'b1;
              found_q      <= best_found_q;
              res_count_q  <= count_q;
              if (best_found_q) begin
                label_q <= LABEL_W'(best_idx_q);
                xmin_q  <= tbl_q[best_idx_q].xmin;
                xmax_q  <= tbl_q[best_idx_q].xmax;
                ymin_q  <= tbl_q[best_idx_q].ymin;
                ymax_q  <= tbl_q[best_idx_q].ymax;
                area_q  <= tbl_q[best_idx_q].area;
              end else begin
                label_q <= '0;
                xmin_q  <= '0;
                xmax_q  <= '0;
                ymin_q  <= '0;
                ymax_q  <= '0;
                area_q  <= '0;
              end
            end else begin
              scan_idx_q <= scan_idx_q + SCAN_W'(1);
              if (w_scan_e.valid) begin
                count_q <= count_q + LABEL_W'(1);
                // Strictly greater keeps the lowest index on ties.
                if (!best_found_q || (w_scan_e.area > best_area_q)) begin
                  best_found_q <= 1'b1;
                  best_idx_q   <= scan_idx_q[IDX_W-1:0];
                  best_area_q  <= w_scan_e.area;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.run_ready  = w_run_ready;
  assign bus.blob_valid = blob_valid_q;
  assign bus.blob_found = found_q;
  assign bus.blob_label = label_q;
  assign bus.blob_xmin  = xmin_q;
  assign bus.blob_xmax  = xmax_q;
  assign bus.blob_ymin  = ymin_q;
  assign bus.blob_ymax  = ymax_q;
  assign bus.blob_area  = area_q;
  assign bus.blob_count = res_count_q;
  assign bus.err_sticky = err_q;

endmodule
`default_nettype wire

// File: doc/blob_bbox_accumulator.md
# blob_bbox_accumulator

Downstream consumer of the two-line run-length blob labeller. Accepts labelled run-length segments (row, start column, end column, label) as the labeller resolves them. Accumulates per-label bounding box and pixel area in a register table. At frame end it scans the table and presents the largest blob's box and area for the tracking logic until the next frame starts.

## Interface
- NUM_LABELS, 16, table entries; labels 0..NUM_LABELS-1 are tracked.
- LABEL_W, 9, label width; matches labeller label width.
- COORD_W, 11, row/column width; covers 1024x768.
- AREA_W, 20, area accumulator width; saturates.

Ports:
- VGA_IN_DATA_CLK  in  1  pixel clock; the only clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- frame_start  in  1  one-cycle pulse; clears table and enters ACCUM.
- frame_end  in  1  one-cycle pulse; starts SCAN, honoured only in ACCUM.
- run_valid  in  1  run segment present.
- run_ready  out  1  block accepts run this cycle.
- run_row  in  COORD_W  row index of segment.
- run_start, run_end  in  COORD_W each  inclusive column bounds.
- run_label  in  LABEL_W  label of segment.
- merge_valid  in  1  equivalence: fold label merge_b into merge_a.
- merge_a, merge_b  in  LABEL_W each  surviving and absorbed labels.
- blob_valid  out  1  level; result registers hold a finished frame.
- blob_found  out  1  at least one valid entry existed at scan.
- blob_label  out  LABEL_W  index of winning entry.
- blob_xmin, blob_xmax, blob_ymin, blob_ymax  out  COORD_W each  box of winner.
- blob_area  out  AREA_W  pixel count of winner.
- blob_count  out  LABEL_W  number of valid entries at scan.
- err_sticky  out  2  bit0 label out of range, bit1 run_end<run_start; cleared by frame_start.

## Operation
- States: IDLE, ACCUM, SCAN, DONE. Reset -> IDLE.
- frame_start from any state: all entry valid bits cleared, err_sticky cleared, blob_valid cleared, next state ACCUM. Wins over frame_end in the same cycle.
- run_ready = (state==ACCUM) && !(merge_valid active).
- Accepted run to an invalid entry: entry valid. xmin=start, xmax=end, ymin=ymax=row, area=end-start+1.
- Accepted run to a valid entry: min/max update, area += end-start+1, saturating at 2^AREA_W-1.
- Run with label >= NUM_LABELS: dropped, err bit0 set. Run with end<start: dropped, err bit1 set.
- Merge in ACCUM, a!=b, both in range:
  - a becomes union of a and b (min/max, saturating area sum, valid = a.valid|b.valid).
  - b invalidated.
- Merge where b is invalid: no-op. Merge where a==b: no-op. Out-of-range merge: no-op, err bit0 set.
- frame_end in ACCUM -> SCAN. Index 0..NUM_LABELS-1 visited one per cycle.
  - Winner is the largest area; ties go to the lowest index.
  - blob_count counts valid entries.
- After last index -> DONE. Result registers loaded, blob_valid=1; held until frame_start or reset.
- blob_found=0 when no valid entry; box/area/label outputs are then 0.
- frame_end in IDLE/SCAN/DONE ignored; runs and merges outside ACCUM are not accepted.

## Timing
- Table update visible the edge after acceptance. Back-to-back runs or merges to the same label accumulate correctly with no bubbles.
- Merge and run same cycle: merge performs, run stalls (run_ready=0).
- blob_valid rises NUM_LABELS+1 cycles after the frame_end cycle.
- Reset values: run_ready=0, blob_valid=0, blob_found=0, all result outputs 0, blob_count=0, err_sticky=0, all entries invalid.
- rst_n asserted mid-SCAN: everything returns to reset values immediately; no partial result is presented.

## Configuration
- BLOB_MERGE_EN defined: merge port functional as above.
- BLOB_MERGE_EN undefined: merge_valid, merge_a and merge_b are ignored. run_ready = (state==ACCUM). Merge logic is not built.

## Test plan
- frame_start, then runs (row5,10..19,L2), (row6,8..15,L2), then frame_end -> after 17 cycles: blob_valid=1, label 2, x 8..19, y 5..6, area 18, count 1.
- Two labels with L1 area 30 and L3 area 30, then frame_end -> winner is label 1 (tie goes to the lower index), count 2.
- Labels: L4 run (row1,0..9), L7 run (row3,20..24); then merge a=4, b=7; then frame_end.
  - With BLOB_MERGE_EN: label 4, box 0..24 x 1..3, area 15, count 1.
  - Without BLOB_MERGE_EN: label 4, area 10, count 2.
- Run with label 20, then run with end=3, start=9 -> both dropped, err_sticky=2'b11; frame_end with no valid runs -> blob_found=0, blob_valid=1.
- rst_n low for 1 cycle during SCAN -> blob_valid=0, run_ready=0, state IDLE; a later frame_start/frame_end cycle with no runs yields a clean result.
